// File: rtl/uart_core_cfg.sv
// Full-duplex UART: ready/valid byte interfaces, configurable data width,
// parity and stop bits. TX and RX share one clock; RX input is synchronised.
module uart_core_cfg #(
    parameter int BAUD_RATE = 115200,
    parameter int CLK_FREQ  = 300000000,
    parameter int BUS_WIDTH = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [BUS_WIDTH-1:0] i_tx_data,
    input  logic                 i_tx_valid,
    output logic                 o_tx_ready,
    output logic                 o_serial,
    output logic                 o_tx_active,
    input  logic                 i_data,
    output logic [BUS_WIDTH-1:0] o_rx_data,
    output logic                 o_rx_valid,
    input  logic                 i_rx_ready,
    output logic                 o_rx_frame_err,
    output logic                 o_rx_parity_err,
    output logic                 o_rx_overrun
);
    localparam int CPB   = CLK_FREQ / BAUD_RATE;
    localparam int CNT_W = $clog2(CPB);
    localparam int BIT_W = $clog2(BUS_WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CPB - 1);
    localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(CPB / 2 - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(BUS_WIDTH - 1);
    localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

    // ---------------- transmitter ----------------
    state_e                 tx_state_q, tx_state_d;
    logic [CNT_W-1:0]       tx_cnt_q, tx_cnt_d;
    logic [BIT_W-1:0]       tx_bit_q, tx_bit_d;
    logic [BUS_WIDTH-1:0]   tx_shreg_q, tx_shreg_d;
    logic                   tx_par_q, tx_par_d;
    logic                   serial_q, serial_d;
    logic                   tx_tick;

    assign tx_tick     = (tx_cnt_q == CNT_LAST);
    assign o_tx_ready  = (tx_state_q == S_IDLE);
    assign o_tx_active = (tx_state_q != S_IDLE);
    assign o_serial    = serial_q;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shreg_d = tx_shreg_q;
        tx_par_d   = tx_par_q;
        if (tx_state_q != S_IDLE) tx_cnt_d = tx_tick ? '0 : tx_cnt_q + 1'b1;
        case (tx_state_q)
            S_IDLE: if (i_tx_valid) begin
                tx_shreg_d = i_tx_data;
                tx_par_d   = (PARITY == 1) ? ~(^i_tx_data) : (^i_tx_data);
                tx_cnt_d   = '0;
                tx_state_d = S_START;
            end
            S_START: if (tx_tick) begin
                tx_bit_d   = '0;
                tx_state_d = S_DATA;
            end
            S_DATA: if (tx_tick) begin
                tx_shreg_d = tx_shreg_q >> 1;
                tx_bit_d   = tx_bit_q + 1'b1;
                if (tx_bit_q == BIT_LAST) begin
                    tx_bit_d   = '0;
                    tx_state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: if (tx_tick) begin
                tx_bit_d   = '0;
                tx_state_d = S_STOP;
            end
            S_STOP: if (tx_tick) begin
                // the stop-bit index reuses the data bit counter
                if (tx_bit_q == STOP_LAST) tx_state_d = S_IDLE;
                else                       tx_bit_d   = tx_bit_q + 1'b1;
            end
            default: tx_state_d = S_IDLE;
        endcase
        // line level is registered from next state so o_serial never glitches
        case (tx_state_d)
            S_START:  serial_d = 1'b0;
            S_DATA:   serial_d = tx_shreg_d[0];
            S_PARITY: serial_d = tx_par_d;
            default:  serial_d = 1'b1;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            tx_state_q <= S_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shreg_q <= '0;
            tx_par_q   <= 1'b0;
            serial_q   <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shreg_q <= tx_shreg_d;
            tx_par_q   <= tx_par_d;
            serial_q   <= serial_d;
        end
    end

    // ---------------- receiver ----------------
    logic                   sync1_q, sync2_q, rx_prev_q;
    state_e                 rx_state_q, rx_state_d;
    logic [CNT_W-1:0]       rx_cnt_q, rx_cnt_d;
    logic [BIT_W-1:0]       rx_bit_q, rx_bit_d;
    logic [BUS_WIDTH-1:0]   rx_shreg_q, rx_shreg_d;
    logic                   rx_fperr_q, rx_fperr_d;
    logic [BUS_WIDTH-1:0]   rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   rx_ferr_q, rx_ferr_d;
    logic                   rx_perr_q, rx_perr_d;
    logic                   overrun_q, overrun_d;
    logic                   rx_tick, rx_done;

    assign rx_tick         = (rx_cnt_q == CNT_LAST);
    assign o_rx_data       = rx_data_q;
    assign o_rx_valid      = rx_valid_q;
    assign o_rx_frame_err  = rx_ferr_q;
    assign o_rx_parity_err = rx_perr_q;
    assign o_rx_overrun    = overrun_q;

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shreg_d = rx_shreg_q;
        rx_fperr_d = rx_fperr_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        rx_ferr_d  = rx_ferr_q;
        rx_perr_d  = rx_perr_q;
        overrun_d  = overrun_q;
        rx_done    = 1'b0;
        if (rx_state_q != S_IDLE) rx_cnt_d = rx_tick ? '0 : rx_cnt_q + 1'b1;
        case (rx_state_q)
            // edge (not level) detect, so a held-low break cannot re-trigger
            S_IDLE: if (rx_prev_q && !sync2_q) begin
                rx_cnt_d   = '0;
                rx_fperr_d = 1'b0;
                rx_state_d = S_START;
            end
            S_START: if (rx_cnt_q == CNT_HALF) begin
                rx_cnt_d   = '0;
                rx_bit_d   = '0;
                rx_state_d = sync2_q ? S_IDLE : S_DATA;
            end
            S_DATA: if (rx_tick) begin
                rx_shreg_d = {sync2_q, rx_shreg_q[BUS_WIDTH-1:1]};
                rx_bit_d   = rx_bit_q + 1'b1;
                if (rx_bit_q == BIT_LAST) rx_state_d = (PARITY != 0) ? S_PARITY : S_STOP;
            end
            S_PARITY: if (rx_tick) begin
                rx_fperr_d = (PARITY == 1) ? ~(^{rx_shreg_q, sync2_q}) : (^{rx_shreg_q, sync2_q});
                rx_state_d = S_STOP;
            end
            S_STOP: if (rx_tick) begin
                rx_done    = 1'b1;
                rx_state_d = S_IDLE;
            end
            default: rx_state_d = S_IDLE;
        endcase
        if (rx_valid_q && i_rx_ready) rx_valid_d = 1'b0;
        if (rx_done) begin
            if (rx_valid_q && !i_rx_ready) begin
                overrun_d = 1'b1;
            end else begin
                rx_data_d  = rx_shreg_q;
                rx_ferr_d  = ~sync2_q;
                rx_perr_d  = rx_fperr_q;
                rx_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= S_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shreg_q <= '0;
            rx_fperr_q <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_ferr_q  <= 1'b0;
            rx_perr_q  <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            sync1_q    <= i_data;
            sync2_q    <= sync1_q;
            rx_prev_q  <= sync2_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shreg_q <= rx_shreg_d;
            rx_fperr_q <= rx_fperr_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rx_ferr_q  <= rx_ferr_d;
            rx_perr_q  <= rx_perr_d;
            overrun_q  <= overrun_d;
        end
    end
endmodule

// File: tb/tb_uart_core_cfg.sv
// Scoreboard bench: main instance 8E2 (loopback or injected line), second
// instance 8N1 for the transmit waveform; both run at 10 clocks per bit.
module tb_uart_core_cfg;
    localparam int CPB = 10;

    typedef struct {
        logic [7:0] d;
        logic       fe;
        logic       pe;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [7:0] tx_data;
    logic       tx_valid, tx_ready, serial, tx_active;
    logic       loop_en, inj_line, rx_in;
    logic [7:0] rx_data;
    logic       rx_valid, ferr, perr, ovr;
    logic       rx_ready = 1'b1;

    logic [7:0] b_tx_data, b_rx_data;
    logic       b_tx_valid, b_tx_ready, b_serial, b_active;
    logic       b_rx_valid, b_ferr, b_perr, b_ovr;

    assign rx_in = loop_en ? serial : inj_line;

    uart_core_cfg #(.BAUD_RATE(100000), .CLK_FREQ(1000000), .BUS_WIDTH(8),
                    .PARITY(2), .STOP_BITS(2)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_tx_data(tx_data), .i_tx_valid(tx_valid), .o_tx_ready(tx_ready),
        .o_serial(serial), .o_tx_active(tx_active),
        .i_data(rx_in), .o_rx_data(rx_data), .o_rx_valid(rx_valid),
        .i_rx_ready(rx_ready), .o_rx_frame_err(ferr), .o_rx_parity_err(perr),
        .o_rx_overrun(ovr));

    uart_core_cfg #(.BAUD_RATE(100000), .CLK_FREQ(1000000), .BUS_WIDTH(8),
                    .PARITY(0), .STOP_BITS(1)) dut_8n1 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_tx_data(b_tx_data), .i_tx_valid(b_tx_valid), .o_tx_ready(b_tx_ready),
        .o_serial(b_serial), .o_tx_active(b_active),
        .i_data(1'b1), .o_rx_data(b_rx_data), .o_rx_valid(b_rx_valid),
        .i_rx_ready(1'b1), .o_rx_frame_err(b_ferr), .o_rx_parity_err(b_perr),
        .o_rx_overrun(b_ovr));

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];
    int   gaps[$];
    int   low_cnt = 0;
    int   rdy_mode = 1;   // 0 hold low, 1 always accept, 2 random

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: drive consumer ready, pop and compare on every acceptance,
    // and record how long o_tx_ready stays low per frame.
    always @(negedge clk) begin
        exp_t e;
        if (rdy_mode == 0)      rx_ready = 1'b0;
        else if (rdy_mode == 1) rx_ready = 1'b1;
        else                    rx_ready = 1'($urandom_range(0, 1));
        if (rst_n && rx_valid && rx_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rx_unexpected actual=%0h required=none", rx_data);
            end else begin
                e = sb.pop_front();
                chk("rx_data", rx_data, e.d);
                chk("rx_frame_err", ferr, e.fe);
                chk("rx_parity_err", perr, e.pe);
            end
        end
        if (!tx_ready) low_cnt++;
        else if (low_cnt != 0) begin
            gaps.push_back(low_cnt);
            low_cnt = 0;
        end
    end

    task automatic send_tx(input logic [7:0] b, input bit push);
        int   n;
        exp_t e;
        n = 0;
        tx_data  = b;
        tx_valid = 1'b1;
        while (!tx_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!tx_ready) begin
            checks++;
            errors++;
            $display("FAIL tx_ready_timeout actual=0 required=1");
        end else if (push) begin
            e.d = b; e.fe = 1'b0; e.pe = 1'b0;
            sb.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic wait_tx_idle();
        int n;
        n = 0;
        while (!tx_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("tx_idle_timeout", tx_ready, 1);
        repeat (30) @(negedge clk);
    endtask

    task automatic wait_sb_empty();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("sb_drain", sb.size(), 0);
    endtask

    // Even-parity 8E2 frame on the injected line
    task automatic inject(input logic [7:0] d, input bit flip, input bit bad_stop, input bit push);
        logic [11:0] fr;
        logic        par;
        exp_t        e;
        par = 1'(($countones(d) % 2) == 1) ^ flip;
        fr  = {1'b1, ~bad_stop, par, d, 1'b0};
        if (push) begin
            e.d = d; e.fe = bad_stop; e.pe = flip;
            sb.push_back(e);
        end
        for (int i = 0; i < 12; i++) begin
            inj_line = fr[i];
            repeat (CPB) @(negedge clk);
        end
        inj_line = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    initial begin
        logic [9:0] fr;
        exp_t       e;
        rst_n = 1'b0; tx_valid = 1'b0; tx_data = '0;
        b_tx_valid = 1'b0; b_tx_data = '0;
        loop_en = 1'b1; inj_line = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_serial", serial, 1);
        chk("rst_tx_ready", tx_ready, 1);
        chk("rst_tx_active", tx_active, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_flags", {ferr, perr, ovr}, 0);
        chk("rst_8n1_rx", {b_rx_data, b_rx_valid, b_ferr, b_perr, b_ovr}, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // 8N1 waveform of 0xA5
        chk("a5_ready_pre", b_tx_ready, 1);
        b_tx_data = 8'hA5; b_tx_valid = 1'b1;
        @(negedge clk);
        b_tx_valid = 1'b0;
        fr = {1'b1, 8'hA5, 1'b0};
        for (int k = 0; k < 10 * CPB; k++) begin
            chk("a5_serial", b_serial, fr[k / CPB]);
            chk("a5_ready_low", b_tx_ready, 0);
            chk("a5_active", b_active, 1);
            @(negedge clk);
        end
        chk("a5_ready_back", b_tx_ready, 1);
        chk("a5_active_end", b_active, 0);
        chk("a5_idle_line", b_serial, 1);

        // back-to-back loopback, 8E2: 12 bits per frame
        gaps.delete();
        send_tx(8'h00, 1); send_tx(8'hFF, 1); send_tx(8'h3C, 1);
        tx_valid = 1'b0;
        wait_tx_idle();
        chk("gap_count", gaps.size(), 3);
        foreach (gaps[i]) chk("gap_len", gaps[i], 12 * CPB);
        wait_sb_empty();

        // parity and framing errors
        loop_en = 1'b0;
        inject(8'h01, 1, 0, 1);
        inject(8'h5C, 0, 1, 1);
        wait_sb_empty();

        // 3-cycle glitch, then a clean frame
        inj_line = 1'b0;
        repeat (3) @(negedge clk);
        inj_line = 1'b1;
        repeat (20) @(negedge clk);
        chk("glitch_no_valid", rx_valid, 0);
        inject(8'h5A, 0, 0, 1);
        wait_sb_empty();

        // break: exactly one zero frame with frame error
        e.d = 8'h00; e.fe = 1'b1; e.pe = 1'b0;
        sb.push_back(e);
        inj_line = 1'b0;
        repeat (400) @(negedge clk);
        inj_line = 1'b1;
        repeat (40) @(negedge clk);
        wait_sb_empty();

        // randomized mix of loopback and injected frames, random backpressure
        rdy_mode = 2;
        for (int i = 0; i < 16; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                loop_en = 1'b1;
                send_tx(8'($urandom_range(0, 255)), 1);
                tx_valid = 1'b0;
                wait_tx_idle();
            end else begin
                loop_en = 1'b0;
                inject(8'($urandom_range(0, 255)), $urandom_range(0, 3) == 0,
                       $urandom_range(0, 3) == 0, 1);
            end
        end
        wait_sb_empty();
        rdy_mode = 1;
        repeat (5) @(negedge clk);

        // overrun
        chk("ovr_pre", ovr, 0);
        rdy_mode = 0;
        loop_en = 1'b0;
        inject(8'h11, 0, 0, 1);
        inject(8'h22, 0, 0, 0);
        repeat (20) @(negedge clk);
        chk("ovr_valid_held", rx_valid, 1);
        chk("ovr_data_kept", rx_data, 8'h11);
        chk("ovr_set", ovr, 1);
        rdy_mode = 1;
        wait_sb_empty();
        repeat (5) @(negedge clk);
        chk("ovr_sticky", ovr, 1);
        chk("ovr_valid_clr", rx_valid, 0);

        // reset mid data bit 3, then a clean frame
        loop_en = 1'b1;
        send_tx(8'hF0, 0);
        tx_valid = 1'b0;
        repeat (44) @(negedge clk);
        chk("pre_rst_bit3", serial, 0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mid_rst_serial", serial, 1);
        chk("mid_rst_ready", tx_ready, 1);
        chk("mid_rst_active", tx_active, 0);
        chk("mid_rst_ovr", ovr, 0);
        chk("mid_rst_rx_valid", rx_valid, 0);
        send_tx(8'h81, 1);
        tx_valid = 1'b0;
        wait_tx_idle();
        wait_sb_empty();

        chk("sb_final_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_core_cfg.md
Name: uart_core_cfg

Overview:
- Next-generation full-duplex UART for the serial link.
- Transmitter and receiver share one clock. Data width, parity mode and stop-bit count are parametrised.
- Ready/valid handshakes on both the TX and RX byte interfaces.
- RX reports framing, parity and overrun errors. Sits between fabric logic and the board serial pins.

Parameters:
BAUD_RATE, 115200, line bit rate
CLK_FREQ, 300000000, i_clk frequency in Hz; CLKS_PER_BIT = CLK_FREQ/BAUD_RATE (integer division, must be >= 4)
BUS_WIDTH, 8, data bits per frame (5..9), sent LSB first
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, stop bits (1 or 2)

Ports:
i_clk  in  1  clock, all logic on rising edge
i_rst_n  in  1  synchronous active-low reset
i_tx_data  in  BUS_WIDTH  byte to transmit
i_tx_valid  in  1  i_tx_data valid
o_tx_ready  out  1  transmitter can accept a byte
o_serial  out  1  serial TX line, idle high
o_tx_active  out  1  frame in progress on o_serial
i_data  in  1  serial RX line (asynchronous)
o_rx_data  out  BUS_WIDTH  received byte
o_rx_valid  out  1  o_rx_data valid, held until accepted
i_rx_ready  in  1  consumer accepts o_rx_data
o_rx_frame_err  out  1  stop bit sampled low, frame of current o_rx_data
o_rx_parity_err  out  1  parity mismatch, frame of current o_rx_data
o_rx_overrun  out  1  sticky; a frame completed while o_rx_valid=1 and unaccepted

Behaviour:
- Reset (i_rst_n=0 at a clock edge): o_serial=1, o_tx_ready=1, o_tx_active=0, o_rx_valid=0, o_rx_data=0, all error flags 0. Both FSMs return to IDLE. Counters clear.
- Reset mid-frame aborts the frame; no partial byte is delivered.
- TX FSM: IDLE -> START -> DATA -> PARITY (skipped if PARITY=0) -> STOP -> IDLE.
  - Handshake occurs when i_tx_valid & o_tx_ready at an edge. i_tx_data is captured then; o_tx_ready drops the next cycle.
  - o_serial goes low (start bit) on the cycle after the handshake.
  - Every bit is held exactly CLKS_PER_BIT cycles. Data is sent LSB first.
  - Parity bit: odd makes the count of ones over data+parity odd; even makes it even.
  - STOP holds o_serial=1 for STOP_BITS*CLKS_PER_BIT cycles.
  - o_tx_ready=1 only in IDLE. It reasserts on the cycle after the last stop cycle. Back-to-back frames therefore add no extra idle bit.
  - o_tx_active=1 from start bit through the last stop cycle.
- RX input: i_data passes through a 2-FF synchroniser (2 cycles of latency) before any use.
- RX FSM: IDLE -> START -> DATA -> PARITY (optional) -> STOP -> IDLE.
  - IDLE: a falling edge (synchronised line low) enters START.
  - START: sample at CLKS_PER_BIT/2. If the line is high there, it is a false start: return to IDLE with no output.
  - DATA and PARITY bits are sampled every CLKS_PER_BIT cycles after the start mid-point.
  - STOP: only the first stop bit is sampled. Low sets frame error. After that sample the FSM returns to IDLE and can detect a new start immediately.
- RX delivery:
  - At the stop sample, o_rx_data, o_rx_frame_err and o_rx_parity_err update, and o_rx_valid=1 on the next cycle.
  - o_rx_valid stays high until o_rx_valid & i_rx_ready; it clears the cycle after acceptance.
  - A frame completing while o_rx_valid=1 and not accepted that same cycle: the new byte is discarded, the old data is kept, and o_rx_overrun=1.
  - A frame completing on the same edge as acceptance is delivered normally.
  - o_rx_overrun clears only on reset.
  - Frames with errors are still delivered with their flags set.
- Break (line held low): yields data 0 with a frame error. The receiver waits for the line to return high before re-arming. No repeated frames are produced during the break.
- Bit counters are sized $clog2(CLKS_PER_BIT) and $clog2(BUS_WIDTH+1). There is no wrap-around beyond terminal values.

Test Plan:
- CLK_FREQ=1000000, BAUD_RATE=100000, 8N1: send 0xA5 -> o_serial low 10 cycles, then bits 1,0,1,0,0,1,0,1 at 10 cycles each, then high 10 cycles. o_tx_ready low for 100 cycles.
- Loopback o_serial->i_data with PARITY=2, STOP_BITS=2: send 0x00, 0xFF, 0x3C back to back -> o_rx_data matches each, no error flags set, o_tx_ready gaps exactly 120 cycles.
- Inject an even-parity frame of 0x01 with the parity bit flipped -> o_rx_data=0x01, o_rx_parity_err=1. Inject stop bit=0 -> o_rx_frame_err=1.
- 3-cycle low glitch on i_data -> no o_rx_valid; the receiver correctly receives 0x5A sent 20 cycles later.
- Hold i_rx_ready=0, receive 0x11 then 0x22 -> o_rx_data stays 0x11, o_rx_overrun=1 after the second frame, flag holds after acceptance.
- Assert i_rst_n=0 for 1 cycle mid-TX data bit 3 -> o_serial=1 and o_tx_ready=1 the next cycle. A new byte 0x81 then transmits cleanly.
